modulo_n_updown: RTL and testbench

MODULO_N_UPDOWN -- requirements
Module: modulo_N_updown

---
 rtl/counter_pkg.sv | 10 +
 rtl/modulo_n_updown.sv | 78 +++++++
 tb/tb_modulo_n_updown.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the modulo-N counter family.
// Boundary behaviour encodings used by the counter MODE parameter.
package counter_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

endpackage : counter_pkg

// File: rtl/modulo_n_updown.sv
// Modulo-N up/down counter with synchronous load, terminal count for cascading
// and a registered wrap pulse. Boundary behaviour is wrap or saturate per MODE.
module modulo_n_updown
    import counter_pkg::*;
#(
    parameter int    N     = 10,
    parameter int    WIDTH = $clog2(N),
    parameter mode_e MODE  = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             up,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             wrap
);

    if (N < 2) begin : g_chk_n
        $error("modulo_n_updown: N must be at least 2");
    end
    if (WIDTH < $clog2(N)) begin : g_chk_width
        $error("modulo_n_updown: WIDTH too narrow to hold N-1");
    end

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(N - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] out_q, out_d;
    logic             wrap_q, wrap_d;
    logic             at_max, at_zero;

    assign at_max  = (out_q == MAX_VAL);
    assign at_zero = (out_q == '0);

    always_comb begin
        out_d  = out_q;
        wrap_d = 1'b0;
        if (ld) begin
            // Out-of-range load values clamp so the count never leaves 0..N-1.
            out_d = (ld_val > MAX_VAL) ? MAX_VAL : ld_val;
        end else if (ce) begin
            if (up) begin
                if (!at_max) begin
                    out_d = out_q + ONE;
                end else if (MODE == MODE_WRAP) begin
                    out_d  = '0;
                    wrap_d = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    out_d = out_q - ONE;
                end else if (MODE == MODE_WRAP) begin
                    out_d  = MAX_VAL;
                    wrap_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            wrap_q <= wrap_d;
        end
    end

    // Masked by rst and ld since those edges never take a counting step.
    assign tc   = ce & ~rst & ~ld & ((up & at_max) | (~up & at_zero));
    assign out  = out_q;
    assign wrap = wrap_q;

endmodule : modulo_n_updown

// File: tb/tb_modulo_n_updown.sv
// Scoreboard bench for modulo_n_updown: wrap and saturate instances share
// stimulus, plus a two-stage decade cascade.
module tb_modulo_n_updown;
    import counter_pkg::*;

    localparam int N = 10;
    localparam int W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1, ce = 1'b0, up = 1'b1, ld = 1'b0;
    logic [W-1:0] ld_val = '0;
    logic [W-1:0] out_w, out_s;
    logic         tc_w, tc_s, wrap_w, wrap_s;

    logic         c_rst = 1'b1;
    logic         c_ce0 = 1'b1, c_up = 1'b1, c_ld = 1'b0;
    logic [W-1:0] c_ldv = '0;
    logic [W-1:0] c0_out, c1_out;
    logic         c0_tc, c1_tc, c0_wrap, c1_wrap;

    modulo_n_updown #(.N(N), .WIDTH(W), .MODE(MODE_WRAP)) dut_w (
        .clk(clk), .rst(rst), .ce(ce), .up(up), .ld(ld), .ld_val(ld_val),
        .out(out_w), .tc(tc_w), .wrap(wrap_w));

    modulo_n_updown #(.N(N), .WIDTH(W), .MODE(MODE_SAT)) dut_s (
        .clk(clk), .rst(rst), .ce(ce), .up(up), .ld(ld), .ld_val(ld_val),
        .out(out_s), .tc(tc_s), .wrap(wrap_s));

    modulo_n_updown #(.N(N), .WIDTH(W), .MODE(MODE_WRAP)) cas0 (
        .clk(clk), .rst(c_rst), .ce(c_ce0), .up(c_up), .ld(c_ld), .ld_val(c_ldv),
        .out(c0_out), .tc(c0_tc), .wrap(c0_wrap));

    modulo_n_updown #(.N(N), .WIDTH(W), .MODE(MODE_WRAP)) cas1 (
        .clk(clk), .rst(c_rst), .ce(c0_tc), .up(c_up), .ld(c_ld), .ld_val(c_ldv),
        .out(c1_out), .tc(c1_tc), .wrap(c1_wrap));

    int checks = 0;
    int errors = 0;

    typedef struct {
        string tag;
        int    exp;
    } exp_t;
    exp_t sb[$];

    int mo_w = 0, mo_s = 0, mw_w = 0, mw_s = 0;
    int ccnt = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] actual(input string tag);
        case (tag)
            "out_wrap":  return 32'(out_w);
            "wrap_wrap": return 32'(wrap_w);
            "out_sat":   return 32'(out_s);
            "wrap_sat":  return 32'(wrap_s);
            "c0_out":    return 32'(c0_out);
            "c1_out":    return 32'(c1_out);
            "c0_wrap":   return 32'(c0_wrap);
            "c1_wrap":   return 32'(c1_wrap);
            default:     return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Reference next state: returns {wrap, out}.
    function automatic void model(input int o, input bit sat, input bit r, input bit l,
                                  input bit c, input bit u, input int lv,
                                  output int no, output int nw);
        nw = 0;
        if (r)       no = 0;
        else if (l)  no = (lv > N - 1) ? N - 1 : lv;
        else if (!c) no = o;
        else if (u) begin
            if (o < N - 1)  no = o + 1;
            else if (sat)   no = N - 1;
            else begin no = 0; nw = 1; end
        end else begin
            if (o > 0)      no = o - 1;
            else if (sat)   no = 0;
            else begin no = N - 1; nw = 1; end
        end
    endfunction

    function automatic int tc_model(input int o, input bit r, input bit l, input bit c, input bit u);
        if (r || l || !c) return 0;
        return (u ? (o == N - 1) : (o == 0)) ? 1 : 0;
    endfunction

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, actual(e.tag), 32'(e.exp));
        end
    endtask

    task automatic cycle(input bit r, input bit c, input bit u, input bit l, input int lv);
        @(negedge clk);
        rst = r; ce = c; up = u; ld = l; ld_val = W'(lv);
        #1;
        check("tc_wrap", 32'(tc_w), 32'(tc_model(mo_w, r, l, c, u)));
        check("tc_sat",  32'(tc_s), 32'(tc_model(mo_s, r, l, c, u)));
        model(mo_w, 1'b0, r, l, c, u, lv, mo_w, mw_w);
        model(mo_s, 1'b1, r, l, c, u, lv, mo_s, mw_s);
        sb.push_back('{tag: "out_wrap",  exp: mo_w});
        sb.push_back('{tag: "wrap_wrap", exp: mw_w});
        sb.push_back('{tag: "out_sat",   exp: mo_s});
        sb.push_back('{tag: "wrap_sat",  exp: mw_s});
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic ccycle(input bit r);
        int prev;
        @(negedge clk);
        c_rst = r;
        #1;
        check("c0_tc", 32'(c0_tc), 32'((!r && ccnt % 10 == 9) ? 1 : 0));
        check("c1_tc", 32'(c1_tc), 32'((!r && ccnt == 99) ? 1 : 0));
        prev = ccnt;
        ccnt = r ? 0 : (ccnt + 1) % 100;
        sb.push_back('{tag: "c0_out",  exp: ccnt % 10});
        sb.push_back('{tag: "c1_out",  exp: ccnt / 10});
        sb.push_back('{tag: "c0_wrap", exp: (!r && prev % 10 == 9) ? 1 : 0});
        sb.push_back('{tag: "c1_wrap", exp: (!r && prev == 99) ? 1 : 0});
        @(posedge clk);
        #1;
        drain();
    endtask

    initial begin
        // Reset state
        cycle(1, 0, 1, 0, 0);
        cycle(1, 1, 1, 1, 5);
        check("reset_out", 32'(out_w), 32'd0);

        // Count up 12 edges from reset: 1..9,0,1,2
        for (int i = 0; i < 12; i++) cycle(0, 1, 1, 0, 0);
        check("up12_out_wrap", 32'(out_w), 32'd2);
        check("up12_out_sat",  32'(out_s), 32'd9);

        // Count down from 0
        cycle(1, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0);
        check("down3_out_wrap", 32'(out_w), 32'd7);

        // Loads: plain, clamp, load beats count, reset beats load
        cycle(0, 0, 1, 1, 7);
        cycle(0, 0, 0, 1, 15);
        check("ld_clamp", 32'(out_w), 32'd9);
        cycle(0, 1, 1, 1, 3);
        cycle(1, 1, 1, 1, 6);

        // Saturate past top then reverse
        cycle(0, 0, 1, 1, 8);
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0);
        cycle(0, 1, 0, 0, 0);
        check("sat_reverse", 32'(out_s), 32'd8);

        // Direction change without dead cycle
        cycle(0, 0, 1, 1, 5);
        cycle(0, 1, 1, 0, 0);
        cycle(0, 1, 0, 0, 0);

        // ce toggling and reset mid-count at the boundary
        for (int i = 0; i < 12; i++) cycle(0, i % 2 == 0, 1, 0, 0);
        cycle(0, 0, 1, 1, 9);
        cycle(1, 1, 1, 0, 0);
        cycle(0, 1, 1, 0, 0);

        // Randomised mix
        for (int i = 0; i < 300; i++)
            cycle($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
                  int'($urandom_range(0, 15)));

        // Cascade: 100 edges returns to 00 with stage-1 wrap
        ccycle(1);
        for (int i = 0; i < 100; i++) ccycle(0);
        check("cas100_value", 32'(c1_out * 10 + c0_out), 32'd0);
        check("cas100_wrap1", 32'(c1_wrap), 32'd1);
        for (int i = 0; i < 56; i++) ccycle(0);
        check("cas56_value", 32'(c1_out * 10 + c0_out), 32'd56);
        ccycle(1);
        check("cas_rst_value", 32'(c1_out * 10 + c0_out), 32'd0);
        ccycle(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_modulo_n_updown
